// File: rtl/l4_sched.sv
// rtl/l4_sched.sv - layer-4 input sequencer: fetches activations, paces strt/din per pass, handshakes results
`timescale 1ns/1ps
module l4_sched #(
    parameter int N_IN = 100,
    parameter int PASS = 5,
    parameter int AW   = 7
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_go,
    output logic                o_src_rd,
    output logic [AW-1:0]       o_src_addr,
    input  logic signed [17:0]  i_src_data,
    output logic                o_l4_strt,
    output logic signed [17:0]  o_l4_din,
    output logic                o_l4_tx_done,
    output logic                o_busy,
    output logic                o_out_vld,
    input  logic                i_out_ack
);

    localparam int PW = (PASS > 1) ? $clog2(PASS) : 1;
    localparam logic [PW-1:0] PH_LAST   = PW'(PASS - 1);
    // Read strobe is registered, so it is scheduled one phase early to be high in phase 2.
    localparam logic [PW-1:0] PH_PRE_RD = PW'(1);
    localparam logic [PW-1:0] PH_CAP    = PW'(3);
    localparam logic [AW-1:0] IDX_LAST  = AW'(N_IN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_CLR
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_phase;
    logic [AW-1:0]       r_idx;
    logic signed [17:0]  r_pref;
    logic                r_src_rd;
    logic [AW-1:0]       r_src_addr;
    logic                r_l4_strt;
    logic signed [17:0]  r_l4_din;
    logic                r_tx_done;
    logic                r_busy;
    logic                r_out_vld;

    // Sequencer FSM: all outputs registered; din only changes on the pass boundary edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_idx      <= '0;
            r_pref     <= '0;
            r_src_rd   <= 1'b0;
            r_src_addr <= '0;
            r_l4_strt  <= 1'b0;
            r_l4_din   <= '0;
            r_tx_done  <= 1'b0;
            r_busy     <= 1'b0;
            r_out_vld  <= 1'b0;
        end else begin
            r_src_rd  <= 1'b0;
            r_l4_strt <= 1'b0;
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_go) begin
                        r_state    <= S_PRE;
                        r_busy     <= 1'b1;
                        r_src_rd   <= 1'b1;
                        r_src_addr <= '0;
                    end
                end
                S_PRE: begin
                    r_state   <= S_RUN;
                    r_phase   <= '0;
                    r_idx     <= '0;
                    r_l4_din  <= i_src_data;
                    r_l4_strt <= 1'b1;
                end
                S_RUN: begin
                    if (r_phase == PH_LAST) begin
                        r_phase <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_l4_din  <= r_pref;
                            r_l4_strt <= 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                    if (r_phase == PH_PRE_RD && r_idx != IDX_LAST) begin
                        r_src_rd   <= 1'b1;
                        r_src_addr <= r_idx + 1'b1;
                    end
                    if (r_phase == PH_CAP) begin
                        r_pref <= i_src_data;
                    end
                end
                S_DRAIN: begin
                    r_state   <= S_OUT;
                    r_out_vld <= 1'b1;
                end
                S_OUT: begin
                    if (i_out_ack) begin
                        r_state   <= S_CLR;
                        r_out_vld <= 1'b0;
                        r_tx_done <= 1'b1;
                    end
                end
                S_CLR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_src_rd     = r_src_rd;
    assign o_src_addr   = r_src_addr;
    assign o_l4_strt    = r_l4_strt;
    assign o_l4_din     = r_l4_din;
    // Layer 4 is held in clear for as long as reset is asserted.
    assign o_l4_tx_done = r_tx_done | i_rst;
    assign o_busy       = r_busy;
    assign o_out_vld    = r_out_vld;

endmodule

// File: tb/tb_l4_sched.sv
// tb/tb_l4_sched.sv - scoreboard bench for l4_sched with randomized activation buffers
`timescale 1ns/1ps
module tb_l4_sched;

    localparam int N_IN = 100;
    localparam int PASS = 5;
    localparam int AW   = 7;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               go = 1'b0;
    logic               out_ack = 1'b0;
    logic               src_rd;
    logic [AW-1:0]      src_addr;
    logic signed [17:0] src_data;
    logic               l4_strt;
    logic signed [17:0] l4_din;
    logic               l4_tx_done;
    logic               busy;
    logic               out_vld;

    always #5 clk = ~clk;

    l4_sched #(.N_IN(N_IN), .PASS(PASS), .AW(AW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_go         (go),
        .o_src_rd     (src_rd),
        .o_src_addr   (src_addr),
        .i_src_data   (src_data),
        .o_l4_strt    (l4_strt),
        .o_l4_din     (l4_din),
        .o_l4_tx_done (l4_tx_done),
        .o_busy       (busy),
        .o_out_vld    (out_vld),
        .i_out_ack    (out_ack)
    );

    // Activation buffer: word is presented while the strobe is high and for one cycle after; junk otherwise.
    logic signed [17:0] mem [0:N_IN-1];
    int                 cyc = 0;
    logic               rst_prev = 1'b0;
    logic               rd_prev = 1'b0;
    logic [AW-1:0]      last_addr = '0;
    logic signed [17:0] junk = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst;
        rd_prev  <= src_rd;
        if (src_rd) last_addr <= src_addr;
        junk     <= 18'($urandom);
    end

    always_comb begin
        src_data = junk;
        if (src_rd && int'(src_addr) < N_IN) src_data = mem[int'(src_addr)];
        else if (!src_rd && rd_prev && int'(last_addr) < N_IN) src_data = mem[int'(last_addr)];
    end

    // Reference model state: expected events and level windows.
    typedef struct {
        int     cyc;
        longint val;
    } ev_t;

    ev_t    q_strt[$];
    ev_t    q_rd[$];
    int     q_txd[$];
    int     busy_lo = 1, busy_hi = 0;
    int     vld_lo = 1, vld_hi = 0;
    longint din_val = 0;
    int     din_until = -1;
    int     n_chk = 0;
    int     n_fail = 0;
    ev_t    m_e;
    int     m_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares every DUT output against the model each cycle, away from the active edge.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (rst) check("tx_done_in_reset", longint'(l4_tx_done), 1);
            if (rst_prev) begin
                check("rst_src_rd", longint'(src_rd), 0);
                check("rst_src_addr", longint'(src_addr), 0);
                check("rst_strt", longint'(l4_strt), 0);
                check("rst_din", longint'(l4_din), 0);
                check("rst_busy", longint'(busy), 0);
                check("rst_out_vld", longint'(out_vld), 0);
            end else begin
                check("busy_level", longint'(busy), longint'(cyc >= busy_lo && cyc <= busy_hi));
                check("out_vld_level", longint'(out_vld), longint'(cyc >= vld_lo && cyc <= vld_hi));
                if (l4_strt) begin
                    if (q_strt.size() == 0) begin
                        check("strt_unexpected", 1, 0);
                    end else begin
                        m_e = q_strt.pop_front();
                        check("strt_cycle", cyc, m_e.cyc);
                        check("strt_din", longint'(l4_din), m_e.val);
                        din_val   = m_e.val;
                        din_until = cyc + PASS - 1;
                    end
                end else if (cyc <= din_until) begin
                    check("din_stable", longint'(l4_din), din_val);
                end
                if (src_rd) begin
                    if (q_rd.size() == 0) begin
                        check("src_rd_unexpected", 1, 0);
                    end else begin
                        m_e = q_rd.pop_front();
                        check("src_rd_cycle", cyc, m_e.cyc);
                        check("src_addr", longint'(src_addr), m_e.val);
                    end
                end
                if (l4_tx_done && !rst) begin
                    if (q_txd.size() == 0) begin
                        check("tx_done_unexpected", 1, 0);
                    end else begin
                        m_t = q_txd.pop_front();
                        check("tx_done_cycle", cyc, m_t);
                    end
                end
            end
        end
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // fill: 0 = ramp i-50, 1 = random, 2 = random with full-scale extremes
    task automatic fill(input int mode);
        for (int i = 0; i < N_IN; i++) begin
            if (mode == 0) mem[i] = 18'(i - 50);
            else mem[i] = 18'($urandom);
        end
        if (mode == 2) begin
            mem[0]  = 18'sh20000;
            mem[50] = -18'sd1;
            mem[99] = 18'sh1ffff;
        end
    endtask

    // Issues go at cycle g and records the whole expected inference from the schedule rules.
    task automatic start_run(input int g, input int ack_delay, input int mode);
        int a;
        goto(g);
        fill(mode);
        for (int k = 0; k < N_IN; k++) begin
            q_strt.push_back('{g + 2 + PASS * k, longint'(mem[k])});
            if (k == 0) q_rd.push_back('{g + 1, 0});
            else q_rd.push_back('{g + 2 + PASS * (k - 1) + 2, longint'(k)});
        end
        a       = g + 2 + PASS * N_IN + 1 + ack_delay;
        busy_lo = g + 1;
        vld_lo  = g + 2 + PASS * N_IN + 1;
        vld_hi  = a;
        busy_hi = a + 1;
        q_txd.push_back(a + 1);
        go      = 1'b1;
        out_ack = (ack_delay == 0);
        goto(g + 1);
        go      = 1'b0;
    endtask

    task automatic flush_after(input int lim);
        while (q_strt.size() > 0 && q_strt[$].cyc > lim) void'(q_strt.pop_back());
        while (q_rd.size() > 0 && q_rd[$].cyc > lim) void'(q_rd.pop_back());
        q_txd.delete();
        busy_hi = lim;
        vld_lo  = 1;
        vld_hi  = 0;
        if (din_until > lim) din_until = lim;
    endtask

    initial begin
        rst = 1'b1;
        goto(3);
        rst = 1'b0;

        start_run(5, 0, 0);

        start_run(515, 20, 1);
        goto(515 + 523);
        out_ack = 1'b1;
        goto(515 + 524);
        out_ack = 1'b0;

        start_run(1045, 0, 2);
        goto(1045 + 100);
        go = 1'b1;
        goto(1045 + 101);
        go = 1'b0;
        goto(1045 + 503);
        go = 1'b1;
        goto(1045 + 504);
        go = 1'b0;
        start_run(1045 + 505, 0, 1);

        start_run(2060, 0, 1);
        goto(2060 + 250);
        rst = 1'b1;
        flush_after(2060 + 250);
        goto(2060 + 252);
        rst = 1'b0;

        start_run(2320, 0, 1);
        goto(2840);

        check("strt_missing", q_strt.size(), 0);
        check("src_rd_missing", q_rd.size(), 0);
        check("tx_done_missing", q_txd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
